// File: rtl/ad100_pkg.sv
// Shared widths, default RAM window placement and the response-owner encoding
// for the two-port RAM arbiter.
package ad100_pkg;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RAM_AW = 13;
  localparam logic [ADDR_W-RAM_AW-1:0] RAM_BASE = 17'h0E000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/ad100_starve_cnt.sv
// Saturating count of consecutive cycles the DMA port was left waiting.
module ad100_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  localparam int unsigned W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                  cnt_d = '0;
    else if (inc && !at_limit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ad100_ram_arb.sv
// Fixed-priority CPU/DMA arbiter onto one single-cycle RAM, with DMA
// anti-starvation and a one-stage response pipeline.
module ad100_ram_arb #(
  parameter int unsigned RAM_AW       = ad100_pkg::RAM_AW,
  parameter logic [ad100_pkg::ADDR_W-RAM_AW-1:0] RAM_BASE = ad100_pkg::RAM_BASE,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m0_req,
  input  logic                         m0_we,
  input  logic [ad100_pkg::ADDR_W-1:0] m0_addr,
  input  logic [ad100_pkg::DATA_W-1:0] m0_wdata,
  output logic                         m0_gnt,
  output logic                         m0_rvalid,
  output logic [ad100_pkg::DATA_W-1:0] m0_rdata,
  input  logic                         m1_req,
  input  logic                         m1_we,
  input  logic [ad100_pkg::ADDR_W-1:0] m1_addr,
  input  logic [ad100_pkg::DATA_W-1:0] m1_wdata,
  output logic                         m1_gnt,
  output logic                         m1_rvalid,
  output logic [ad100_pkg::DATA_W-1:0] m1_rdata,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [RAM_AW-1:0]            ram_addr,
  output logic [ad100_pkg::DATA_W-1:0] ram_wdata,
  input  logic [ad100_pkg::DATA_W-1:0] ram_rdata
);
  import ad100_pkg::*;

  req_t   r0, r1, sel;
  logic   g0, g1, hit, at_limit;
  owner_e owner_q, owner_d;
  logic   zero_q, zero_d;

  assign r0 = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign r1 = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};

  // Grants are gated by rst_n so nothing leaks out while reset is held.
  always_comb begin
    g1  = rst_n && m1_req && (!m0_req || at_limit);
    g0  = rst_n && m0_req && !g1;
    sel = g1 ? r1 : r0;
    hit = (sel.addr[ADDR_W-1:RAM_AW] == RAM_BASE);
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign ram_en    = (g0 || g1) && hit;
  assign ram_we    = ram_en && sel.we;
  assign ram_addr  = sel.addr[RAM_AW-1:0];
  assign ram_wdata = sel.wdata;

  ad100_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (m1_req && !g1),
    .clr      (!m1_req || g1),
    .at_limit (at_limit)
  );

  // Writes and out-of-window reads still respond, but with zero data.
  always_comb begin
    owner_d = g0 ? OWN_M0 : (g1 ? OWN_M1 : OWN_NONE);
    zero_d  = !hit || sel.we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      zero_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      zero_q  <= zero_d;
    end
  end

  assign m0_rvalid = (owner_q == OWN_M0);
  assign m1_rvalid = (owner_q == OWN_M1);
  assign m0_rdata  = (m0_rvalid && !zero_q) ? ram_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !zero_q) ? ram_rdata : '0;
endmodule
